// File: rtl/fc_arbiter.sv
// Two-port command arbiter and sequencer for the flash controller: round-robin grants on fc_done,
// immediate consumption of zero-length requests, idle scratch command and a sticky watchdog.
module fc_arbiter #(
    parameter logic [32:0] IDLE_CMD = 33'h1_0000_3F81,
    parameter logic [19:0] TIMEOUT  = 20'd1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_req,
    input  logic [32:0] r0_cmd,
    output logic        r0_ack,
    output logic        r0_done,
    input  logic        r1_req,
    input  logic [32:0] r1_cmd,
    output logic        r1_ack,
    output logic        r1_done,
    output logic [32:0] fc_cmd,
    input  logic        fc_done,
    output logic        busy,
    output logic        owner,
    output logic        err
);
    localparam logic [1:0] S_BOOT     = 2'd0;
    localparam logic [1:0] S_RUN_REQ  = 2'd1;
    localparam logic [1:0] S_RUN_IDLE = 2'd2;

    logic [1:0]  r_state;
    logic [32:0] r_fc_cmd;
    logic [1:0]  r_ack;
    logic [1:0]  r_done;
    logic        r_owner;
    logic        r_last;
    logic [19:0] r_wd_cnt;
    logic        r_err;

    logic [1:0]  w_req;
    logic [32:0] w_cmd [2];
    logic [1:0]  w_zero;
    logic [1:0]  w_elig;
    logic [1:0]  w_ack_next;
    logic [1:0]  w_done_next;
    logic        w_grant_valid;
    logic        w_grant_id;
    logic [19:0] w_wd_next;

    assign w_req    = {r1_req, r0_req};
    assign w_cmd[0] = r0_cmd;
    assign w_cmd[1] = r1_cmd;

    // A requester still holds req during its ack cycle, so that cycle must not be seen as a new request.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign w_zero[gi] = w_req[gi] && (w_cmd[gi][6:0] == 7'd0) && !r_ack[gi];
            assign w_elig[gi] = w_req[gi] && (w_cmd[gi][6:0] != 7'd0) && !r_ack[gi];
            assign w_ack_next[gi]  = w_zero[gi]
                                   | (fc_done && w_grant_valid && (w_grant_id == 1'(gi)));
            assign w_done_next[gi] = w_zero[gi]
                                   | (fc_done && (r_state == S_RUN_REQ) && (r_owner == 1'(gi)));
        end
    endgenerate

    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_id    = 1'b0;
        if (w_elig == 2'b11) begin
            w_grant_valid = 1'b1;
            w_grant_id    = ~r_last;
        end else if (w_elig[0]) begin
            w_grant_valid = 1'b1;
            w_grant_id    = 1'b0;
        end else if (w_elig[1]) begin
            w_grant_valid = 1'b1;
            w_grant_id    = 1'b1;
        end
    end

    always_comb begin
        if (fc_done)
            w_wd_next = 20'd0;
        else if (r_wd_cnt == 20'hF_FFFF)
            w_wd_next = r_wd_cnt;
        else
            w_wd_next = r_wd_cnt + 20'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_BOOT;
            r_fc_cmd <= IDLE_CMD;
            r_ack    <= 2'b00;
            r_done   <= 2'b00;
            r_owner  <= 1'b0;
            r_last   <= 1'b1;
            r_wd_cnt <= 20'd0;
            r_err    <= 1'b0;
        end else begin
            r_ack    <= w_ack_next;
            r_done   <= w_done_next;
            r_wd_cnt <= w_wd_next;
            if (w_wd_next == TIMEOUT)
                r_err <= 1'b1;
            if (fc_done) begin
                if (w_grant_valid) begin
                    r_fc_cmd <= w_cmd[w_grant_id];
                    r_owner  <= w_grant_id;
                    r_last   <= w_grant_id;
                    r_state  <= S_RUN_REQ;
                end else begin
                    r_fc_cmd <= IDLE_CMD;
                    r_state  <= S_RUN_IDLE;
                end
            end
        end
    end

    assign fc_cmd  = r_fc_cmd;
    assign r0_ack  = r_ack[0];
    assign r1_ack  = r_ack[1];
    assign r0_done = r_done[0];
    assign r1_done = r_done[1];
    assign busy    = (r_state == S_RUN_REQ);
    assign owner   = r_owner;
    assign err     = r_err;
endmodule
